// File: rtl/png_filter_mc.sv
// png_filter_mc -- PNG scanline filter for the encoder datapath.
//
// Takes a raster byte stream of cfg_h_i rows x cfg_w_i pixels x cfg_bpp_i
// bytes/pixel. Each row is emitted as one filter-type byte followed by the
// filtered bytes. The filter type (None/Sub/Up/Average/Paeth) is fixed per frame.
// An internal line buffer holds the previous row. Each location is read one
// cycle before the current byte overwrites it.
//
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   cfg_w_i/h_i/bpp_i   frame geometry, latched on start_i in IDLE
//   cfg_type_i          filter type 0..4 (5..7 act as 0)
//   start_i, done_o     frame start pulse / one-cycle frame-complete pulse
//   in_val_i/rdy_o/dat_i    raw byte stream (valid/ready)
//   out_val_o/rdy_i/dat_o   type byte + filtered bytes (valid/ready)
module png_filter_mc #(
    parameter int DATA_WD   = 8,
    parameter int BPP_MAX   = 4,
    parameter int SIZE_W_WD = 13,
    parameter int SIZE_H_WD = 13,
    parameter int LINE_MAX  = 8192
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SIZE_W_WD-1:0] cfg_w_i,
    input  logic [SIZE_H_WD-1:0] cfg_h_i,
    input  logic [2:0]           cfg_bpp_i,
    input  logic [2:0]           cfg_type_i,
    input  logic                 start_i,
    output logic                 done_o,
    input  logic                 in_val_i,
    output logic                 in_rdy_o,
    input  logic [DATA_WD-1:0]   in_dat_i,
    output logic                 out_val_o,
    input  logic                 out_rdy_i,
    output logic [DATA_WD-1:0]   out_dat_o
);
    localparam int AW = $clog2(LINE_MAX);
    localparam int NW = SIZE_W_WD + 3;

    typedef enum logic [2:0] {S_IDLE, S_TYPE, S_ROW, S_FLUSH, S_DONE} state_t;
    typedef enum logic [2:0] {F_NONE, F_SUB, F_UP, F_AVG, F_PAETH} ftype_t;

    state_t               state, state_nx;
    logic [NW-1:0]        n_bytes, byte_cnt;
    logic [SIZE_H_WD-1:0] h_q, row_cnt;
    logic [2:0]           bpp_q;
    ftype_t               type_q;

    logic                 stall, hs, advance;
    logic                 s1_val;
    logic [DATA_WD-1:0]   s1_x, rd_q;
    logic [AW-1:0]        s1_idx;
    logic [DATA_WD-1:0]   a_sr [BPP_MAX];
    logic [DATA_WD-1:0]   c_sr [BPP_MAX];
    logic [DATA_WD-1:0]   mem  [LINE_MAX];

    logic [DATA_WD-1:0]   a, b, c, pred, filt;
    logic [DATA_WD:0]     sum;
    logic signed [10:0]   p, da, db, dc;
    logic [10:0]          pa, pb, pc;

    // A held output freezes the whole pipeline, including the input side.
    assign stall    = out_val_o & ~out_rdy_i;
    assign in_rdy_o = (state == S_ROW) & ~stall & (byte_cnt < n_bytes);
    assign hs       = in_val_i & in_rdy_o;
    assign advance  = s1_val & ~stall;
    assign done_o   = (state == S_DONE);

    // NOTE: every variable gets a default before the case, so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_i) state_nx = S_TYPE;
            S_TYPE:  if (!stall) state_nx = S_ROW;
            S_ROW:   if (hs && byte_cnt == n_bytes - NW'(1)) state_nx = S_FLUSH;
            // The exit coincides with the final output handshake of the row.
            S_FLUSH: if (!s1_val && !stall)
                         state_nx = (row_cnt == h_q - SIZE_H_WD'(1)) ? S_DONE : S_TYPE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            n_bytes  <= '0;
            byte_cnt <= '0;
            h_q      <= '0;
            row_cnt  <= '0;
            bpp_q    <= '0;
            type_q   <= F_NONE;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start_i) begin
                n_bytes  <= NW'(cfg_w_i) * NW'(cfg_bpp_i);
                h_q      <= cfg_h_i;
                bpp_q    <= cfg_bpp_i;
                type_q   <= (cfg_type_i > 3'd4) ? F_NONE : ftype_t'(cfg_type_i);
                row_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (hs) byte_cnt <= byte_cnt + NW'(1);
            if (state == S_FLUSH && state_nx == S_TYPE) begin
                row_cnt  <= row_cnt + SIZE_H_WD'(1);
                byte_cnt <= '0;
            end
        end
    end

    // NOTE: the line buffer has no reset. Row 0 never uses its contents because b/c are forced to 0.
    always_ff @(posedge clk) begin
        if (hs)      rd_q        <= mem[byte_cnt[AW-1:0]];
        if (advance) mem[s1_idx] <= s1_x;
    end

    // Operand selection and filter arithmetic on the stage-1 byte.
    always_comb begin
        a = '0;
        c = '0;
        for (int k = 0; k < BPP_MAX; k++) begin
            if (bpp_q == 3'(k + 1)) begin
                a = a_sr[k];
                c = c_sr[k];
            end
        end
        b   = (row_cnt == '0) ? '0 : rd_q;
        sum = {1'b0, a} + {1'b0, b};
        p   = $signed({3'b0, a}) + $signed({3'b0, b}) - $signed({3'b0, c});
        da  = p - $signed({3'b0, a});
        db  = p - $signed({3'b0, b});
        dc  = p - $signed({3'b0, c});
        pa  = da[10] ? $unsigned(-da) : $unsigned(da);
        pb  = db[10] ? $unsigned(-db) : $unsigned(db);
        pc  = dc[10] ? $unsigned(-dc) : $unsigned(dc);
        case (type_q)
            F_SUB:   pred = a;
            F_UP:    pred = b;
            F_AVG:   pred = sum[DATA_WD:1];
            F_PAETH: begin
                if (pa <= pb && pa <= pc) pred = a;
                else if (pb <= pc)        pred = b;
                else                      pred = c;
            end
            default: pred = '0;
        endcase
        filt = s1_x - pred;
    end

    // Stage 1 (x + buffer read) and the output register; both hold on stall.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_val    <= 1'b0;
            s1_x      <= '0;
            s1_idx    <= '0;
            out_val_o <= 1'b0;
            out_dat_o <= '0;
            for (int k = 0; k < BPP_MAX; k++) begin
                a_sr[k] <= '0;
                c_sr[k] <= '0;
            end
        end else begin
            // The a/c history restarts at every row; TYPE precedes every row.
            if (state == S_TYPE) begin
                for (int k = 0; k < BPP_MAX; k++) begin
                    a_sr[k] <= '0;
                    c_sr[k] <= '0;
                end
            end else if (advance) begin
                a_sr[0] <= s1_x;
                c_sr[0] <= b;
                for (int k = 1; k < BPP_MAX; k++) begin
                    a_sr[k] <= a_sr[k-1];
                    c_sr[k] <= c_sr[k-1];
                end
            end
            if (!stall) begin
                s1_val <= hs;
                if (hs) begin
                    s1_x   <= in_dat_i;
                    s1_idx <= byte_cnt[AW-1:0];
                end
                if (s1_val) begin
                    out_val_o <= 1'b1;
                    out_dat_o <= filt;
                end else if (state == S_TYPE) begin
                    out_val_o <= 1'b1;
                    out_dat_o <= DATA_WD'(type_q);
                end else begin
                    out_val_o <= 1'b0;
                end
            end
        end
    end
endmodule
